mem_load_dump_ctrl: RTL
=======================

Name: mem_load_dump_ctrl

Overview:
Synthesizable loader/dumper for the 3-stage processor's memories. It replaces simulation-only memory preload and post-run dump with a byte-stream command interface. The block writes words into any of NUM_TGT target memories (instruction memory, register file, CSR file, ...), holds the core in reset while loading, and releases it on command. When the core signals completion, it re-holds the core in reset so the host can read back any target.

Parameters:
DATA_W, 32, target word width in bits; must be a multiple of 8.
ADDR_W, 10, target word-address width.
NUM_TGT, 3, number of target memories; one-hot select width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  command/data byte valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  8  host byte
out_valid  out  1  response byte valid
out_ready  in  1  host accepts out_data
out_data  out  8  response byte
mem_sel  out  NUM_TGT  one-hot target select; qualifies mem_we and mem_re
mem_we  out  1  write strobe, single cycle
mem_re  out  1  read strobe, single cycle
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re
cpu_rst  out  1  reset to processor core, active-high
cpu_done  in  1  core finished (level)

Behaviour:
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, mem_sel=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - cpu_rst=1, FSM=IDLE, all counters 0.
- Reset is asynchronous. Asserting it mid-operation aborts the transfer with no further mem_we, and drops any pending response byte.
- Handshakes:
  - An input byte transfers when in_valid && in_ready.
  - An output byte transfers when out_valid && out_ready.
  - out_valid and out_data are held stable until the byte is accepted.
- Frame format: 6-byte header = CMD, TGT, ADDR[7:0], ADDR[15:8], CNT[7:0], CNT[15:8].
  - ADDR is truncated to ADDR_W.
  - CNT is the number of words.
- Commands:
  - CMD 0x01 LOAD: followed by CNT x (DATA_W/8) bytes, each word little-endian.
  - CMD 0x02 DUMP.
  - CMD 0x03 RUN.
- Error conditions:
  - Unknown CMD, or TGT >= NUM_TGT (checked after the TGT byte) -> emit 0xEE, then IDLE.
  - Any remaining header bytes of an errored frame are not consumed.
- FSM states: IDLE, HDR, LD_BYTE, LD_WR, RD_REQ, RD_CAP, TX_BYTE, ACK, RUNNING.
- IDLE/HDR: in_ready=1. After byte 6, branch on CMD.
- LOAD, and DUMP, with CNT=0: go straight to ACK, with no memory access.
- LOAD (LD_BYTE / LD_WR):
  - in_ready=1 in LD_BYTE; bytes shift into a word register.
  - On the last byte of a word, go to LD_WR.
  - LD_WR lasts one cycle with in_ready=0: mem_we=1, mem_sel=1<<TGT, mem_addr=current address, mem_wdata=assembled word.
  - Address then increments modulo 2^ADDR_W (wrap-around permitted, no error).
  - After CNT words -> ACK.
- DUMP (RD_REQ / RD_CAP / TX_BYTE):
  - RD_REQ: mem_re=1 for one cycle.
  - RD_CAP: capture mem_rdata.
  - TX_BYTE: emit DATA_W/8 bytes, LSB first, with back-pressure honoured.
  - Address increments as for LOAD. After CNT words -> ACK.
  - Best case is 2 + DATA_W/8 cycles per word.
- ACK: emit 0x4B, then IDLE.
- RUN:
  - Allowed only when cpu_rst=1. If the core is already running -> 0xEE.
  - Otherwise cpu_rst goes to 0 on the cycle after the CMD header completes, then the FSM enters RUNNING (in_ready=0).
- RUNNING: on cpu_done=1, cpu_rst goes to 1 on the next edge, then emit 0xD0, then IDLE.
- While in RUNNING, mem_we and mem_re stay at 0.
- mem_we and mem_re are never asserted in the same cycle.
- mem_sel is nonzero only when mem_we or mem_re is asserted.

Test Plan:
- Reset release: after rst falls -> cpu_rst=1, in_ready=1, out_valid=0, mem_we=0.
- LOAD TGT0 ADDR 0x0000 CNT 2, words 0x00500093, 0x00100113:
  - mem_we pulses at addr 0 and addr 1 with exactly those data values and mem_sel=3'b001.
  - Then out 0x4B.
- DUMP TGT1 ADDR 0x03FF CNT 2 with ADDR_W=10 and a memory model returning addr+0x100:
  - mem_re at addr 0x3FF then 0x000 (wrap).
  - Out bytes FF 04 00 00, 00 01 00 00, then 4B.
  - Hold out_ready=0 for 5 cycles mid-word -> bytes still correct and stable.
- Errors:
  - CMD 0x07 -> out 0xEE, no memory strobes.
  - LOAD with TGT=3 (NUM_TGT=3) -> 0xEE after the second byte.
- RUN, then cpu_done pulse after 20 cycles:
  - cpu_rst falls after the header, rises 1 cycle after cpu_done.
  - Out 0xD0. A second RUN issued during the run window is ignored because in_ready=0.
- Assert rst mid-LOAD after 3 of 4 bytes of word 0:
  - No mem_we occurs and the FSM returns to IDLE.
  - A subsequent full LOAD works normally.

Source files
------------

// File: rtl/mem_load_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_dump_ctrl
// Brief    : Byte-stream loader/dumper for the core's target memories. Loads
//            words while the core is held in reset, releases the core on RUN,
//            and re-holds it once the core reports completion so targets can
//            be read back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_dump_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int NUM_TGT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [7:0]         in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [7:0]         out_data_o,
    output logic [NUM_TGT-1:0] mem_sel_o,
    output logic               mem_we_o,
    output logic               mem_re_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               cpu_rst_o,
    input  logic               cpu_done_i
);

    localparam int         NB        = DATA_W / 8;
    localparam logic [7:0] LAST_BYTE = 8'(NB - 1);
    localparam logic [8:0] NUM_TGT_B = 9'(NUM_TGT);

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_DUMP  = 8'h02;
    localparam logic [7:0] CMD_RUN   = 8'h03;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'hEE;
    localparam logic [7:0] RSP_DONE  = 8'hD0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HDR     = 4'd1,
        S_LD_BYTE = 4'd2,
        S_LD_WR   = 4'd3,
        S_RD_REQ  = 4'd4,
        S_RD_CAP  = 4'd5,
        S_TX_BYTE = 4'd6,
        S_ACK     = 4'd7,
        S_RUNNING = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic                live_q, live_d;      // low only in the first cycle after reset
    logic                cpu_rst_q, cpu_rst_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          tgt_q, tgt_d;
    logic [7:0]          lo_q, lo_d;          // low byte of a 16-bit header field
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         cnt_q, cnt_d;        // words remaining
    logic [7:0]          idx_q, idx_d;        // header byte index / byte-in-word index
    logic [DATA_W-1:0]   word_q, word_d;
    logic [7:0]          rsp_q, rsp_d;

    logic                w_in_rdy;
    logic                w_in_fire;
    logic [15:0]         w_field;
    logic [NUM_TGT-1:0]  w_sel;

    assign w_in_rdy  = live_q && (state_q == S_IDLE || state_q == S_HDR ||
                                  state_q == S_LD_BYTE);
    assign w_in_fire = in_valid_i && w_in_rdy;
    assign w_field   = {in_data_i, lo_q};
    assign w_sel     = NUM_TGT'(1) << tgt_q;

    assign in_ready_o  = w_in_rdy;
    assign mem_sel_o   = (mem_we_o || mem_re_o) ? w_sel : '0;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = word_q;
    assign cpu_rst_o   = cpu_rst_q;

    // State and datapath registers; reset aborts any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            live_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            cmd_q     <= '0;
            tgt_q     <= '0;
            lo_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            cpu_rst_q <= cpu_rst_d;
            cmd_q     <= cmd_d;
            tgt_q     <= tgt_d;
            lo_q      <= lo_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            rsp_q     <= rsp_d;
        end
    end

    // Next-state, datapath updates and strobe/response outputs
    always_comb begin
        state_d     = state_q;
        live_d      = 1'b1;
        cpu_rst_d   = cpu_rst_q;
        cmd_d       = cmd_q;
        tgt_d       = tgt_q;
        lo_d        = lo_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        word_d      = word_q;
        rsp_d       = rsp_q;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (w_in_fire) begin
                    if (in_data_i == CMD_LOAD || in_data_i == CMD_DUMP ||
                        in_data_i == CMD_RUN) begin
                        cmd_d   = in_data_i;
                        idx_d   = 8'd1;
                        state_d = S_HDR;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = S_ACK;
                    end
                end
            end

            S_HDR: begin
                if (w_in_fire) begin
                    idx_d = idx_q + 8'd1;
                    case (idx_q)
                        8'd1: begin
                            tgt_d = in_data_i;
                            if ({1'b0, in_data_i} >= NUM_TGT_B) begin
                                rsp_d   = RSP_ERR;
                                state_d = S_ACK;
                            end
                        end
                        8'd2: lo_d = in_data_i;
                        8'd3: addr_d = ADDR_W'(w_field);
                        8'd4: lo_d = in_data_i;
                        default: begin
                            // Last header byte: the count is complete, branch on command
                            cnt_d = w_field;
                            idx_d = 8'd0;
                            if (cmd_q == CMD_RUN) begin
                                if (cpu_rst_q) begin
                                    cpu_rst_d = 1'b0;
                                    state_d   = S_RUNNING;
                                end else begin
                                    rsp_d   = RSP_ERR;
                                    state_d = S_ACK;
                                end
                            end else if (w_field == 16'd0) begin
                                rsp_d   = RSP_ACK;
                                state_d = S_ACK;
                            end else if (cmd_q == CMD_LOAD) begin
                                state_d = S_LD_BYTE;
                            end else begin
                                state_d = S_RD_REQ;
                            end
                        end
                    endcase
                end
            end

            S_LD_BYTE: begin
                if (w_in_fire) begin
                    // Little-endian: each new byte enters at the top and shifts down
                    word_d = (word_q >> 8) | (DATA_W'(in_data_i) << (DATA_W - 8));
                    if (idx_q == LAST_BYTE) begin
                        idx_d   = 8'd0;
                        state_d = S_LD_WR;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

            S_LD_WR: begin
                mem_we_o = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                cnt_d    = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    rsp_d   = RSP_ACK;
                    state_d = S_ACK;
                end else begin
                    state_d = S_LD_BYTE;
                end
            end

            S_RD_REQ: begin
                mem_re_o = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                state_d  = S_RD_CAP;
            end

            S_RD_CAP: begin
                word_d  = mem_rdata_i;
                idx_d   = 8'd0;
                state_d = S_TX_BYTE;
            end

            S_TX_BYTE: begin
                out_valid_o = 1'b1;
                out_data_o  = word_q[7:0];
                if (out_ready_i) begin
                    word_d = word_q >> 8;
                    if (idx_q == LAST_BYTE) begin
                        idx_d = 8'd0;
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            rsp_d   = RSP_ACK;
                            state_d = S_ACK;
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

            S_ACK: begin
                out_valid_o = 1'b1;
                out_data_o  = rsp_q;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            S_RUNNING: begin
                if (cpu_done_i) begin
                    cpu_rst_d = 1'b1;
                    rsp_d     = RSP_DONE;
                    state_d   = S_ACK;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
